// File: rtl/fft_pkg.sv
// Shared FFT definitions: default sizes, unload FSM states and the bit-reversal helper.
package fft_pkg;

  localparam int unsigned N_DEF            = 8;
  localparam int unsigned BITS_PER_ROW_DEF = 3;
  localparam int unsigned DATA_W_DEF       = 32;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} unload_state_t;

  // Reverses the low 'width' bits of v; bits at or above 'width' come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int unsigned width);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < width) r[5'(i)] = v[5'(width - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/unload_fifo2.sv
// Two-entry synchronous FIFO with occupancy output; the caller never pushes into a full FIFO without a pop.
module unload_fifo2 #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= 2'(count + 2'(push) - 2'(pop));
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/bitrev_unloader.sv
// Unloads one FFT frame from a ping-pong bank at bit-reversed addresses as a natural-order stream.
// Optional macro UNLOAD_INDEX_EN adds the out_index port (natural bin of out_data).
module bitrev_unloader
  import fft_pkg::*;
#(
  parameter int unsigned N            = N_DEF,
  parameter int unsigned BITS_PER_ROW = BITS_PER_ROW_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    bank_sel,
  output logic                    mem_rd_en,
  output logic                    mem_rd_bank,
  output logic [BITS_PER_ROW-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0]       mem_rd_data,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done
`ifdef UNLOAD_INDEX_EN
  ,
  output logic [BITS_PER_ROW-1:0] out_index
`endif
);

  localparam int unsigned CNT_W = BITS_PER_ROW + 1;

  unload_state_t           state;
  logic [CNT_W-1:0]        cnt;
  logic [BITS_PER_ROW-1:0] out_cnt;
  logic                    inflight;
  logic                    bank_q;
  logic [1:0]              fifo_count;
  logic                    pop;

  assign pop       = out_valid && out_ready;
  assign out_valid = (fifo_count != 2'd0);
  assign out_last  = out_valid && (out_cnt == BITS_PER_ROW'(N - 1));

  // Credit check: FIFO occupancy plus the read in flight must leave room for this read.
  assign mem_rd_en   = (state == READ) &&
                       ((3'(fifo_count) + 3'(inflight)) < (3'd2 + 3'(pop)));
  assign mem_rd_addr = BITS_PER_ROW'(bitrev(32'(cnt), BITS_PER_ROW));
  assign mem_rd_bank = bank_q;

  unload_fifo2 #(.DATA_W(DATA_W)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (mem_rd_data),
    .pop       (pop),
    .head      (out_data),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      out_cnt  <= '0;
      inflight <= 1'b0;
      bank_q   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      inflight <= mem_rd_en;
      done     <= 1'b0;
      if (pop) out_cnt <= out_cnt + BITS_PER_ROW'(1);
      case (state)
        IDLE: begin
          if (start) begin
            state   <= READ;
            bank_q  <= bank_sel;
            cnt     <= '0;
            out_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        READ: begin
          if (mem_rd_en) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(N - 1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && (out_cnt == BITS_PER_ROW'(N - 1))) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          bank_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UNLOAD_INDEX_EN
  assign out_index = out_cnt;
`endif

endmodule

// File: tb/tb_bitrev_unloader.sv
// Directed bench for bitrev_unloader: latency, order, backpressure, ignored starts, bank hold, reset abort.
module tb_bitrev_unloader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        bank_sel;
  logic        out_ready;
  logic        mem_rd_en;
  logic        mem_rd_bank;
  logic [2:0]  mem_rd_addr;
  logic [31:0] mem_rd_data;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_last;
  logic        busy;
  logic        done;
`ifdef UNLOAD_INDEX_EN
  logic [2:0]  out_index;
`endif

  int checks = 0;
  int errors = 0;

  int exp_addr [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  int exp_d1   [8] = '{1, 65, 33, 97, 17, 81, 49, 113};
  bit rdy_pat  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  bitrev_unloader #(.N(8), .BITS_PER_ROW(3), .DATA_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .bank_sel    (bank_sel),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_bank (mem_rd_bank),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done)
`ifdef UNLOAD_INDEX_EN
    ,
    .out_index   (out_index)
`endif
  );

  always #5 clk = ~clk;

  // Bank contents: bank 1 holds 16*addr+1, bank 0 holds 16*addr+2; one-cycle read latency.
  always @(posedge clk) begin
    if (mem_rd_en)
      mem_rd_data <= 32'({mem_rd_addr, 4'h0}) + (mem_rd_bank ? 32'd1 : 32'd2);
    else
      mem_rd_data <= 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rd_en"}, 32'(mem_rd_en), 32'd0);
    chk({tag, "_rd_bank"}, 32'(mem_rd_bank), 32'd0);
    chk({tag, "_rd_addr"}, 32'(mem_rd_addr), 32'd0);
    chk({tag, "_out_data"}, out_data, 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_last"}, 32'(out_last), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  // One frame: start on the next edge, then sample each cycle 2 time units after the edge.
  task automatic do_frame(input logic bnk, input bit toggle, input bit flip, input bit poke,
                          input int abort_at);
    int nrd = 0, nout = 0, ndone = 0, s = 0;
    int first_v = 0, last_o = 0, done_s = 0, outstanding = 0, post = 0;
    bit stalled = 1'b0, fin = 1'b0;
    logic [31:0] held = '0;
    logic [31:0] exp_d;
    logic rdy;
    @(posedge clk); #1;
    start = 1'b1; bank_sel = bnk; out_ready = 1'b1;
    while (!fin && s < 80) begin
      @(posedge clk); #1;
      s++;
      if (abort_at != 0 && nout == abort_at) begin
        start = 1'b0;
        return;
      end
      start = poke && (s == 4 || s == 11);
      if (flip && s == 3) bank_sel = ~bnk;
      rdy = toggle ? rdy_pat[(s - 1) % 4] : 1'b1;
      out_ready = rdy;
      #1;
      if (s == 1) begin
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("first_rd_en", 32'(mem_rd_en), 32'd1);
      end
      if (mem_rd_en) begin
        if (nrd < 8) begin
          chk("rd_addr", 32'(mem_rd_addr), 32'(exp_addr[nrd]));
          chk("rd_bank", 32'(mem_rd_bank), 32'(bnk));
        end else begin
          chk("extra_read", 32'(nrd), 32'd7);
        end
        chk("credit", 32'((outstanding - ((out_valid && rdy) ? 1 : 0)) < 2), 32'd1);
        nrd++;
      end
      if (stalled) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", out_data, held);
      end
      if (out_valid) begin
        if (first_v == 0) first_v = s;
        if (nout < 8) begin
          exp_d = 32'(exp_d1[nout]) + (bnk ? 32'd0 : 32'd1);
          chk("out_data", out_data, exp_d);
          chk("out_last", 32'(out_last), 32'(nout == 7));
`ifdef UNLOAD_INDEX_EN
          chk("out_index", 32'(out_index), 32'(nout));
`endif
        end else begin
          chk("extra_output", 32'(nout), 32'd7);
        end
        stalled = !rdy;
        held = out_data;
        if (rdy) begin
          nout++;
          last_o = s;
        end
      end else begin
        stalled = 1'b0;
      end
      if (ndone > 0) begin
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_rd_en", 32'(mem_rd_en), 32'd0);
        chk("idle_bank", 32'(mem_rd_bank), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        post++;
        if (post == 3) fin = 1'b1;
      end
      if (done) begin
        ndone++;
        done_s = s;
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("outs_at_done", 32'(nout), 32'd8);
      end
      outstanding = outstanding + (mem_rd_en ? 1 : 0) - ((out_valid && rdy) ? 1 : 0);
    end
    start = 1'b0;
    bank_sel = 1'b0;
    out_ready = 1'b1;
    if (!fin) chk("frame_timeout", 32'(s), 32'd0);
    chk("num_reads", 32'(nrd), 32'd8);
    chk("num_outputs", 32'(nout), 32'd8);
    chk("num_done", 32'(ndone), 32'd1);
    chk("done_after_last", 32'(done_s), 32'(last_o + 1));
    if (!toggle) begin
      chk("first_valid_latency", 32'(first_v), 32'd3);
      chk("done_cycle", 32'(done_s), 32'd11);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    bank_sel = 1'b0;
    out_ready = 1'b1;
    #2;
    chk_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    do_frame(1'b1, 1'b0, 1'b0, 1'b0, 0);
    do_frame(1'b1, 1'b1, 1'b0, 1'b0, 0);
    do_frame(1'b1, 1'b0, 1'b0, 1'b1, 0);
    do_frame(1'b0, 1'b0, 1'b1, 1'b0, 0);

    do_frame(1'b1, 1'b0, 1'b0, 1'b0, 3);
    rst_n = 1'b0;
    #1;
    chk_zero("abort");
    @(posedge clk);
    #1 rst_n = 1'b1;
    do_frame(1'b1, 1'b0, 1'b0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bitrev_unloader.md
Name: bitrev_unloader

Overview:
- Reads one completed FFT frame out of a ping-pong result bank and emits it as a natural-order valid/ready stream.
- The FFT core leaves results in bit-reversed order. This block therefore reads the bank at bit-reversed addresses, so the output stream is in natural order.
- Sits between the ping-pong dual-port RAM read port and the downstream sample sink. It is the consumer end of the bank that the address generator fills.

Parameters:
- N, 8: transform length; must be a power of two, N >= 4.
- BITS_PER_ROW, 3: log2(N); width of a bank address.
- DATA_W, 32: width of one complex sample word.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to unload a frame; honoured only in IDLE.
- bank_sel  in  1  ping-pong bank to read; sampled when start is accepted.
- mem_rd_en  out  1  read strobe to the RAM.
- mem_rd_bank  out  1  bank select for the read; constant for the whole frame.
- mem_rd_addr  out  BITS_PER_ROW  read address; equals bitrev(cnt).
- mem_rd_data  in  DATA_W  read data; valid exactly 1 cycle after mem_rd_en.
- out_data  out  DATA_W  output sample.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  sink accepts the sample.
- out_last  out  1  high with sample index N-1.
- busy  out  1  high from start acceptance until the done pulse.
- done  out  1  one-cycle pulse after the last output handshake.

Behaviour:
- Reset: all outputs are 0, FSM is IDLE, cnt=0, FIFO is empty, inflight=0. Reset mid-frame aborts the frame with no done pulse; any RAM data still returning is discarded.
- FSM states:
  - IDLE: on start=1, latch bank_sel, set cnt=0, set busy=1, go to READ. If start=1 in any other state, it is ignored.
  - READ: issue reads under the credit rule below. Each issued read increments cnt. After the read with cnt=N-1, go to DRAIN.
  - DRAIN: no reads. When the output handshake for sample N-1 occurs, go to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle, then go to IDLE. A start in the DONE cycle is ignored.
- Address rule: mem_rd_addr[b] = cnt[BITS_PER_ROW-1-b]. cnt is BITS_PER_ROW+1 bits so that it reaches N without wrapping.
- Read pipeline:
  - inflight is 1 bit: a read was issued last cycle.
  - mem_rd_data is written into a 2-entry FIFO at the edge ending the cycle after mem_rd_en.
- Credit rule: mem_rd_en = READ && (count + inflight - pop) < 2, where pop = out_valid && out_ready. This gives full throughput (1 sample/cycle) with out_ready held high, and the FIFO never overflows.
- Latency: start accepted at edge t → first mem_rd_en in cycle t+1 → first out_valid in cycle t+3.
- Output stream:
  - out_valid = FIFO not empty; out_data is the FIFO head.
  - out_valid and out_data stay stable while out_ready=0.
  - out_last is high only with the Nth sample.
- Output index: a separate output counter tracks the handshakes and asserts out_last. The sample is leaving in natural order, so its index equals its natural frequency bin.
- Backpressure: if out_ready=0 indefinitely, reads stall once count+inflight reaches 2. No data is dropped.
- mem_rd_bank holds the latched bank for the whole frame and drops to 0 in IDLE.

Optional Feature:
- Macro: UNLOAD_INDEX_EN.
- Defined: adds output port out_index (BITS_PER_ROW bits) giving the natural bin index of out_data, valid with out_valid. Its value is 0..N-1 in order and equals the output handshake counter.
- Undefined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Shared package fft_pkg:
  - localparam N_DEF, BITS_PER_ROW_DEF, DATA_W_DEF.
  - bitrev function (BITS_PER_ROW-wide).
  - FSM state typedef unload_state_t {IDLE, READ, DRAIN, DONE}.
- One sub-module: unload_fifo2, a 2-entry synchronous FIFO with count output, async active-low reset.

Test Plan:
- N=8, bank 1 preloaded with word = 16*addr+1, out_ready=1, start pulse → mem_rd_addr sequence 0,4,2,6,1,5,3,7 on consecutive cycles; out_data 1,65,33,97,17,81,49,113; out_last with 113; done 1 cycle after; first out_valid 3 cycles after start.
- Same frame, out_ready toggled 1,0,0,1 repeatedly → same 8 words in order, none dropped or duplicated; out_data stable while stalled; mem_rd_en never issues when count+inflight-pop ≥ 2.
- start asserted during READ, and again in the DONE cycle → ignored; exactly 8 outputs, 1 done pulse.
- bank_sel=0 at start, flipped to 1 mid-frame → mem_rd_bank stays 0 for all 8 reads.
- rst_n pulled low after 3 outputs → all outputs 0 immediately; a new start after release produces a complete 8-sample frame starting at addr 0.
- With UNLOAD_INDEX_EN, out_ready=1 → out_index 0..7 aligned with each out_valid.
